// File: rtl/rgbw_pwm_gen_pkg.sv
// rtl/rgbw_pwm_gen_pkg.sv - shared constants and state encoding for the RGBW PWM generator
package rgbw_pwm_gen_pkg;

    localparam logic [7:0] PWM_PERIOD_MAX = 8'd254;
    localparam logic [8:0] PWM_PERIOD     = 9'd255;

    localparam logic [7:0] PWM_OFS_R = 8'd0;
    localparam logic [7:0] PWM_OFS_G = 8'd64;
    localparam logic [7:0] PWM_OFS_B = 8'd128;
    localparam logic [7:0] PWM_OFS_W = 8'd192;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } pwm_state_e;

endpackage

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one PWM channel: shadow/active duty, phase offset and output flop
module pwm_channel
    import rgbw_pwm_gen_pkg::*;
#(
    parameter logic [7:0] OFFSET = 8'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_tick,
    input  logic       i_load_active,
    input  logic       i_load_shadow,
    input  logic       i_apply_shadow,
    input  logic [7:0] i_duty,
    input  logic [7:0] i_count,
    output logic       o_pwm
);

    logic [7:0] r_shadow;
    logic [7:0] r_active;
    logic       r_pwm;
    logic [8:0] w_sum;
    logic [7:0] w_phase;

    // Counter never exceeds 254, so a single conditional subtract is a full mod 255.
    assign w_sum   = {1'b0, i_count} + {1'b0, OFFSET};
    assign w_phase = (w_sum >= PWM_PERIOD) ? 8'(w_sum - PWM_PERIOD) : w_sum[7:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow <= 8'd0;
            r_active <= 8'd0;
            r_pwm    <= 1'b0;
        end else begin
            if (i_tick) begin
                r_pwm <= (w_phase < r_active);
            end
            if (i_load_active) begin
                r_active <= i_duty;
            end else if (i_apply_shadow) begin
                r_active <= r_shadow;
            end
            if (i_load_shadow) begin
                r_shadow <= i_duty;
            end
        end
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/rgbw_pwm_gen.sv
// rtl/rgbw_pwm_gen.sv - four-channel double-buffered PWM top; RGBW_PWM_STAGGER_EN staggers channel phases
module rgbw_pwm_gen
    import rgbw_pwm_gen_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_half,
    input  logic       load,
    input  logic [7:0] duty_r,
    input  logic [7:0] duty_g,
    input  logic [7:0] duty_b,
    input  logic [7:0] duty_w,
    output logic       pwm_r,
    output logic       pwm_g,
    output logic       pwm_b,
    output logic       pwm_w,
    output logic       period_sync,
    output logic       pending
);

`ifdef RGBW_PWM_STAGGER_EN
    localparam logic [7:0] OFS_R = PWM_OFS_R;
    localparam logic [7:0] OFS_G = PWM_OFS_G;
    localparam logic [7:0] OFS_B = PWM_OFS_B;
    localparam logic [7:0] OFS_W = PWM_OFS_W;
`else
    localparam logic [7:0] OFS_R = 8'd0;
    localparam logic [7:0] OFS_G = 8'd0;
    localparam logic [7:0] OFS_B = 8'd0;
    localparam logic [7:0] OFS_W = 8'd0;
`endif

    pwm_state_e r_state;
    pwm_state_e w_state_next;
    logic [7:0] r_count;
    logic       r_pending;
    logic       r_period_sync;

    logic       w_tick;
    logic       w_wrap;
    logic       w_load_active;
    logic       w_load_shadow;
    logic       w_apply_shadow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (r_state == ST_IDLE && load) begin
            w_state_next = ST_RUN;
        end
    end

    // A load landing on the wrap tick bypasses the shadow so it takes effect next period.
    always_comb begin
        w_tick         = 1'b0;
        w_wrap         = 1'b0;
        w_load_active  = 1'b0;
        w_load_shadow  = 1'b0;
        w_apply_shadow = 1'b0;
        if (r_state == ST_IDLE) begin
            w_load_active = load;
        end else begin
            w_tick         = clk_half;
            w_wrap         = clk_half && (r_count == PWM_PERIOD_MAX);
            w_load_active  = load && w_wrap;
            w_load_shadow  = load && !w_wrap;
            w_apply_shadow = w_wrap && r_pending;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count       <= 8'd0;
            r_pending     <= 1'b0;
            r_period_sync <= 1'b0;
        end else begin
            r_period_sync <= w_wrap;
            if (w_wrap) begin
                r_count <= 8'd0;
            end else if (w_tick) begin
                r_count <= r_count + 8'd1;
            end
            if (w_load_shadow) begin
                r_pending <= 1'b1;
            end else if (w_wrap) begin
                r_pending <= 1'b0;
            end
        end
    end

    pwm_channel #(.OFFSET(OFS_R)) u_ch_r (
        .clk(clk), .reset(reset), .i_tick(w_tick), .i_load_active(w_load_active),
        .i_load_shadow(w_load_shadow), .i_apply_shadow(w_apply_shadow),
        .i_duty(duty_r), .i_count(r_count), .o_pwm(pwm_r)
    );

    pwm_channel #(.OFFSET(OFS_G)) u_ch_g (
        .clk(clk), .reset(reset), .i_tick(w_tick), .i_load_active(w_load_active),
        .i_load_shadow(w_load_shadow), .i_apply_shadow(w_apply_shadow),
        .i_duty(duty_g), .i_count(r_count), .o_pwm(pwm_g)
    );

    pwm_channel #(.OFFSET(OFS_B)) u_ch_b (
        .clk(clk), .reset(reset), .i_tick(w_tick), .i_load_active(w_load_active),
        .i_load_shadow(w_load_shadow), .i_apply_shadow(w_apply_shadow),
        .i_duty(duty_b), .i_count(r_count), .o_pwm(pwm_b)
    );

    pwm_channel #(.OFFSET(OFS_W)) u_ch_w (
        .clk(clk), .reset(reset), .i_tick(w_tick), .i_load_active(w_load_active),
        .i_load_shadow(w_load_shadow), .i_apply_shadow(w_apply_shadow),
        .i_duty(duty_w), .i_count(r_count), .o_pwm(pwm_w)
    );

    assign period_sync = r_period_sync;
    assign pending     = r_pending;

endmodule

// File: tb/tb_rgbw_pwm_gen.sv
// tb/tb_rgbw_pwm_gen.sv - self-checking bench for rgbw_pwm_gen against a tick-count model
module tb_rgbw_pwm_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clk_half = 1'b0;
    logic       load = 1'b0;
    logic [7:0] duty_r = 8'd0, duty_g = 8'd0, duty_b = 8'd0, duty_w = 8'd0;
    logic       pwm_r, pwm_g, pwm_b, pwm_w, period_sync, pending;

    always #5 clk = ~clk;

    rgbw_pwm_gen dut (
        .clk(clk), .reset(reset), .clk_half(clk_half), .load(load),
        .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b), .duty_w(duty_w),
        .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b), .pwm_w(pwm_w),
        .period_sync(period_sync), .pending(pending)
    );

    int checks = 0;
    int failures = 0;

    // Model: position in the period is simply (ticks since start) mod 255.
    bit m_run = 1'b0;
    int m_ticks = 0;
    int m_act[4] = '{0, 0, 0, 0};
    int m_sh[4]  = '{0, 0, 0, 0};
    bit m_pend = 1'b0;
    bit e_pwm[4] = '{0, 0, 0, 0};
    bit e_sync = 1'b0;
`ifdef RGBW_PWM_STAGGER_EN
    int ofs[4] = '{0, 64, 128, 192};
`else
    int ofs[4] = '{0, 0, 0, 0};
`endif

    int hi[4] = '{0, 0, 0, 0};
    int sync_n = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit half, input bit ld, input int d[4]);
        bit wrap;
        int pos;
        wrap = 1'b0;
        if (rst) begin
            m_run = 1'b0; m_ticks = 0; m_pend = 1'b0; e_sync = 1'b0;
            for (int i = 0; i < 4; i++) begin m_act[i] = 0; m_sh[i] = 0; e_pwm[i] = 1'b0; end
        end else if (!m_run) begin
            e_sync = 1'b0;
            if (ld) begin
                m_act = d; m_run = 1'b1; m_ticks = 0;
            end
        end else begin
            e_sync = 1'b0;
            if (half) begin
                pos = m_ticks % 255;
                for (int i = 0; i < 4; i++) e_pwm[i] = (((pos + ofs[i]) % 255) < m_act[i]);
                wrap = (pos == 254);
                m_ticks++;
                e_sync = wrap;
            end
            if (wrap) begin
                if (ld) m_act = d;
                else if (m_pend) m_act = m_sh;
                m_pend = 1'b0;
            end else if (ld) begin
                m_sh = d;
                m_pend = 1'b1;
            end
        end
    endtask

    task automatic cyc(input bit rst, input bit half, input bit ld,
                       input int dr, input int dg, input int db, input int dw);
        int d[4];
        d = '{dr, dg, db, dw};
        reset = rst; clk_half = half; load = ld;
        duty_r = 8'(dr); duty_g = 8'(dg); duty_b = 8'(db); duty_w = 8'(dw);
        @(posedge clk);
        model_step(rst, half, ld, d);
        @(negedge clk);
        check("cycle", int'({pwm_r, pwm_g, pwm_b, pwm_w, period_sync, pending}),
              int'({e_pwm[0], e_pwm[1], e_pwm[2], e_pwm[3], e_sync, m_pend}));
        hi[0] += int'(pwm_r); hi[1] += int'(pwm_g); hi[2] += int'(pwm_b); hi[3] += int'(pwm_w);
        sync_n += int'(period_sync);
        load = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) hi[i] = 0;
        sync_n = 0;
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while ((m_ticks % 255) != target && guard < 600) begin
            cyc(1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
            guard++;
        end
        check("run_to_bound", int'(guard < 600), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        check("reset_out", int'({pwm_r, pwm_g, pwm_b, pwm_w, period_sync, pending}), 0);

        clear_counts();
        ticks(600);
        check("idle_sync", sync_n, 0);
        check("idle_high", hi[0] + hi[1] + hi[2] + hi[3], 0);

        cyc(1'b0, 1'b1, 1'b1, 0, 255, 1, 128);
        check("idle_load_pend", int'(pending), 0);
        ticks(1);
        check("b_first_tick", int'(pwm_b), 1);
        check("g_first_tick", int'(pwm_g), 1);
        ticks(1);
        check("b_second_tick", int'(pwm_b), 0);
        ticks(20);
        clear_counts();
        ticks(255);
        check("high_r", hi[0], 0);
        check("high_g", hi[1], 255);
        check("high_b", hi[2], 1);
        check("high_w", hi[3], 128);
        clear_counts();
        ticks(510);
        check("sync_per_510", sync_n, 2);

        run_to(100);
        cyc(1'b0, 1'b1, 1'b1, 200, 255, 1, 128);
        check("pend_at_100", int'(pending), 1);
        clear_counts();
        run_to(150);
        cyc(1'b0, 1'b1, 1'b1, 10, 255, 1, 128);
        check("pend_at_150", int'(pending), 1);
        run_to(0);
        check("r_cur_period", hi[0], 0);
        check("pend_after_wrap", int'(pending), 0);
        clear_counts();
        ticks(255);
        check("r_next_period", hi[0], 10);

        run_to(254);
        cyc(1'b0, 1'b1, 1'b1, 50, 255, 1, 128);
        check("pend_wrap_load", int'(pending), 0);
        check("sync_on_wrap", int'(period_sync), 1);
        clear_counts();
        ticks(255);
        check("r_after_wrap_load", hi[0], 50);

        cyc(1'b0, 1'b0, 1'b1, 64, 64, 64, 64);
        for (int i = 0; i < 300; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
            cyc(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        end
        clear_counts();
        for (int i = 0; i < 255; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
            cyc(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        end
        check("half_high_r", hi[0], 128);
        check("half_high_w", hi[3], 128);
        check("half_sync_510", sync_n, 1);

        run_to(30);
        cyc(1'b0, 1'b1, 1'b1, 77, 64, 64, 64);
        check("pend_before_reset", int'(pending), 1);
        ticks(3);
        cyc(1'b1, 1'b1, 1'b0, 0, 0, 0, 0);
        check("reset_mid", int'({pwm_r, pwm_g, pwm_b, pwm_w, period_sync, pending}), 0);
        clear_counts();
        ticks(5);
        check("post_reset_idle", hi[0] + hi[1] + hi[2] + hi[3] + sync_n, 0);
        cyc(1'b0, 1'b0, 1'b1, 255, 0, 0, 0);
        check("reload_pend", int'(pending), 0);
        check("reload_r_low", int'(pwm_r), 0);
        ticks(1);
        check("reload_first_tick", int'(pwm_r), 1);

`ifdef RGBW_PWM_STAGGER_EN
        cyc(1'b0, 1'b1, 1'b1, 32, 32, 32, 32);
        ticks(300);
        clear_counts();
        ticks(255);
        check("stag_r", hi[0], 32);
        check("stag_g", hi[1], 32);
        check("stag_b", hi[2], 32);
        check("stag_w", hi[3], 32);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
